// File: rtl/fp16_add_issuer_pkg.sv
// Shared fp16 types and constants for the adder issuer and its result buffer.
package fp16_add_issuer_pkg;

  localparam int unsigned FP16_W = 16;

  typedef logic [FP16_W-1:0] fp16_t;

  localparam fp16_t ZERO  = 16'h0000;
  localparam fp16_t ONE   = 16'h3C00;
  localparam fp16_t TWO   = 16'h4000;
  localparam fp16_t THREE = 16'h4200;

endpackage

// File: rtl/fp16_result_fifo.sv
// Synchronous DEPTH-entry result buffer; head is presented directly from storage.
module fp16_result_fifo
  import fp16_add_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  fp16_t                          push_data,
  input  logic                           pop,
  output fp16_t                          head_data,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  fp16_t              mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               pop_ok;

  assign empty     = (count == '0);
  assign pop_ok    = pop & ~empty;
  // Gate the head so the port reads zero whenever nothing is buffered.
  assign head_data = empty ? ZERO : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fp16_add_issuer.sv
// Credit-based issuer to a valid-only fixed-latency fp16 adder; results buffered in order.
module fp16_add_issuer
  import fp16_add_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  fp16_t  in_a,
  input  fp16_t  in_b,
  input  logic   in_valid,
  output logic   in_ready,
  output fp16_t  add_a,
  output fp16_t  add_b,
  output logic   add_valid,
  input  fp16_t  add_res,
  input  logic   add_res_valid,
  output fp16_t  out_data,
  output logic   out_valid,
  input  logic   out_ready,
  output logic   err_unexpected
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] inflight_next;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] fifo_count_next;
  logic [CNT_W:0]   occupancy_next;
  logic             in_ready_next;
  logic             handshake;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  assign handshake = in_valid & in_ready;
  assign push      = add_res_valid & (inflight != '0);
  assign pop       = out_valid & out_ready;
  assign out_valid = ~fifo_empty;

  // in_ready is registered from the next-state occupancy, so in_valid never reaches it combinationally.
  always_comb begin
    inflight_next   = inflight + CNT_W'(handshake) - CNT_W'(push);
    fifo_count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    occupancy_next  = (CNT_W+1)'(fifo_count_next) + (CNT_W+1)'(inflight_next);
    in_ready_next   = occupancy_next < (CNT_W+1)'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight       <= '0;
      in_ready       <= 1'b0;
      add_valid      <= 1'b0;
      add_a          <= ZERO;
      add_b          <= ZERO;
      err_unexpected <= 1'b0;
    end else begin
      inflight  <= inflight_next;
      in_ready  <= in_ready_next;
      add_valid <= handshake;
      if (handshake) begin
        add_a <= in_a;
        add_b <= in_b;
      end
      // A result with nothing outstanding is dropped and latched as an error.
      if (add_res_valid && inflight == '0) err_unexpected <= 1'b1;
    end
  end

  fp16_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (add_res),
    .pop       (pop),
    .head_data (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fp16_add_issuer.sv
// Directed bench for fp16_add_issuer with a 12-cycle table-driven adder model.
module tb_fp16_add_issuer;
  import fp16_add_issuer_pkg::*;

  localparam int DEPTH = 8;
  localparam int LAT   = 12;

  logic  clk = 1'b0;
  logic  rst_n;
  fp16_t in_a, in_b;
  logic  in_valid, in_ready;
  fp16_t add_a, add_b, add_res;
  logic  add_valid, add_res_valid;
  fp16_t out_data;
  logic  out_valid, out_ready, err_unexpected;

  logic  inj_valid;
  fp16_t inj_res;

  int n_chk = 0;
  int n_err = 0;
  int issue_cnt = 0;
  bit inv_bad = 1'b0;
  fp16_t exp_q[$];
  fp16_t got_q[$];

  always #5 clk = ~clk;

  fp16_add_issuer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .add_a          (add_a),
    .add_b          (add_b),
    .add_valid      (add_valid),
    .add_res        (add_res),
    .add_res_valid  (add_res_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .err_unexpected (err_unexpected)
  );

  // Hand-computed fp16 sums for the operand pairs used here.
  function automatic fp16_t fsum(input fp16_t a, input fp16_t b);
    case ({a, b})
      {16'h3C00, 16'h4000}: return 16'h4200;
      {16'h3C00, 16'h0000}: return 16'h3C00;
      {16'h0000, 16'h3C00}: return 16'h3C00;
      {16'h3C00, 16'h3C00}: return 16'h4000;
      {16'h0000, 16'h0000}: return 16'h0000;
      default:              return 16'hFFFF;
    endcase
  endfunction

  // Adder model: not reset, so results issued before a reset still emerge afterwards.
  logic [LAT-1:0] pv = '0;
  fp16_t          pd [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], add_valid};
    pd[0] <= fsum(add_a, add_b);
    for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
  end
  assign add_res_valid = pv[LAT-1] | inj_valid;
  assign add_res       = inj_valid ? inj_res : pd[LAT-1];

  always @(posedge clk) begin
    if (in_valid && in_ready) exp_q.push_back(fsum(in_a, in_b));
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (add_valid) issue_cnt++;
    if (32'(dut.inflight) + 32'(dut.fifo_count) > DEPTH) inv_bad = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready), 0);
    chk({tag, "_add_valid"}, 32'(add_valid), 0);
    chk({tag, "_add_a"},     32'(add_a), 0);
    chk({tag, "_add_b"},     32'(add_b), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"},  32'(out_data), 0);
    chk({tag, "_err"},       32'(err_unexpected), 0);
    chk({tag, "_inflight"},  32'(dut.inflight), 0);
    chk({tag, "_fifo_cnt"},  32'(dut.fifo_count), 0);
    chk({tag, "_wr_ptr"},    32'(dut.u_fifo.wr_ptr), 0);
    chk({tag, "_rd_ptr"},    32'(dut.u_fifo.rd_ptr), 0);
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) step(1);
    chk("drain_count", 32'(got_q.size()), 32'(n));
  endtask

  initial begin
    fp16_t pa [3];
    fp16_t pb [3];
    int    idx;
    bit    seen;
    pa[0] = ONE; pb[0] = TWO;
    pa[1] = ONE; pb[1] = ZERO;
    pa[2] = ONE; pb[2] = ONE;

    rst_n = 1'b0; in_a = ZERO; in_b = ZERO; in_valid = 1'b0;
    out_ready = 1'b1; inj_valid = 1'b0; inj_res = ZERO;
    step(2);
    chk_reset_state("por");
    rst_n = 1'b1;
    step(1);
    chk("ready_after_release", 32'(in_ready), 1);

    // Single add: issue one cycle after handshake, result visible one cycle after arrival.
    in_a = ONE; in_b = TWO; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    chk("single_add_valid", 32'(add_valid), 1);
    chk("single_add_a", 32'(add_a), 32'(ONE));
    chk("single_add_b", 32'(add_b), 32'(TWO));
    step(1);
    chk("single_add_valid_low", 32'(add_valid), 0);
    chk("single_add_a_hold", 32'(add_a), 32'(ONE));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      seen = add_res_valid;
    end
    chk("single_res_seen", 32'(seen), 1);
    chk("single_outv_same_cycle", 32'(out_valid), 0);
    step(1);
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_out_data", 32'(out_data), 32'(THREE));
    step(1);
    chk("single_popped", 32'(got_q.size()), 1);
    chk("single_out_empty", 32'(out_valid), 0);

    // Backpressure fill.
    exp_q.delete(); got_q.delete(); issue_cnt = 0;
    out_ready = 1'b0; in_a = ONE; in_b = ONE; in_valid = 1'b1;
    step(40);
    chk("fill_issues", 32'(issue_cnt), 8);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_out_valid", 32'(out_valid), 1);
    chk("fill_out_data_hold", 32'(out_data), 32'(TWO));
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("fill_ready_after_pop", 32'(in_ready), 1);
    step(1);
    chk("fill_ready_again_low", 32'(in_ready), 0);
    step(30);
    chk("fill_issues_plus_one", 32'(issue_cnt), 9);
    in_valid = 1'b0; out_ready = 1'b1;
    wait_pops(9, 40);
    for (int i = 0; i < got_q.size(); i++) chk("fill_data", 32'(got_q[i]), 32'(TWO));

    // Ordering of back-to-back issues.
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 3; i++) begin
      in_a = pa[i]; in_b = pb[i]; in_valid = 1'b1;
      step(1);
    end
    in_valid = 1'b0;
    wait_pops(3, 40);
    if (got_q.size() == 3) begin
      chk("order_0", 32'(got_q[0]), 32'h4200);
      chk("order_1", 32'(got_q[1]), 32'h3C00);
      chk("order_2", 32'(got_q[2]), 32'h4000);
    end

    // Random concurrent issue / arrival / pop.
    exp_q.delete(); got_q.delete(); inv_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      idx = int'($urandom_range(0, 2));
      in_a = pa[idx]; in_b = pb[idx];
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_pops(exp_q.size(), 60);
    chk("rand_invariant", 32'(inv_bad), 0);
    chk("rand_no_err", 32'(err_unexpected), 0);
    chk("rand_sizes", 32'(got_q.size()), 32'(exp_q.size()));
    if (got_q.size() == exp_q.size())
      for (int i = 0; i < got_q.size(); i++) chk("rand_data", 32'(got_q[i]), 32'(exp_q[i]));

    // Unexpected result with nothing in flight.
    step(20);
    got_q.delete();
    inj_res = ONE; inj_valid = 1'b1;
    step(1);
    inj_valid = 1'b0;
    chk("unexp_err", 32'(err_unexpected), 1);
    step(5);
    chk("unexp_err_sticky", 32'(err_unexpected), 1);
    chk("unexp_no_out", 32'(out_valid), 0);
    chk("unexp_no_pop", 32'(got_q.size()), 0);

    // Reset with 3 adds in flight and 2 buffered.
    out_ready = 1'b0;
    in_a = ONE; in_b = TWO; in_valid = 1'b1; step(1);
    in_a = ONE; in_b = ZERO; step(1);
    in_valid = 1'b0;
    step(16);
    for (int i = 0; i < 3; i++) begin
      in_a = ONE; in_b = ONE; in_valid = 1'b1;
      step(1);
    end
    in_valid = 1'b0;
    step(2);
    chk("pre_rst_inflight", 32'(dut.inflight), 3);
    chk("pre_rst_fifo_cnt", 32'(dut.fifo_count), 2);
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    step(3);
    chk_reset_state("mid_rst_hold");
    rst_n = 1'b1;
    got_q.delete();
    out_ready = 1'b1;
    step(1);
    chk("post_rst_ready", 32'(in_ready), 1);
    step(15);
    chk("post_rst_err", 32'(err_unexpected), 1);
    chk("post_rst_no_out", 32'(out_valid), 0);
    chk("post_rst_no_pop", 32'(got_q.size()), 0);
    chk("post_rst_inflight", 32'(dut.inflight), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fp16_add_issuer.md
FP16_ADD_ISSUER -- requirements
Module: fp16_add_issuer

Interface
REQ-001 Parameter DEPTH, default 8: result FIFO depth and maximum outstanding adds; power of two, at least 2.
REQ-002 Port clk  input  1  the single clock; all state on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port in_a  input  16  fp16 operand A.
REQ-005 Port in_b  input  16  fp16 operand B.
REQ-006 Port in_valid  input  1  operand pair offered.
REQ-007 Port in_ready  output  1  pair accepted when in_valid and in_ready are both high.
REQ-008 Port add_a  output  16  operand A to adder, registered.
REQ-009 Port add_b  output  16  operand B to adder, registered.
REQ-010 Port add_valid  output  1  one-cycle issue strobe to adder; drives both adder operand valids.
REQ-011 Port add_res  input  16  adder result.
REQ-012 Port add_res_valid  input  1  adder result strobe; the adder has no backpressure.
REQ-013 Port out_data  output  16  buffered fp16 sum, FIFO head.
REQ-014 Port out_valid  output  1  FIFO non-empty.
REQ-015 Port out_ready  input  1  consumer pops the head when out_valid and out_ready are both high.
REQ-016 Port err_unexpected  output  1  sticky flag: a result arrived with nothing in flight.

Function
REQ-017 Block SHALL act as initiator to a valid-only, fixed-latency, in-order fp16 adder and SHALL never issue an add whose result cannot be stored.
REQ-018 inflight counter, width clog2(DEPTH+1):
- +1 on each input handshake.
- -1 on each accepted add_res_valid.
REQ-019 credit = DEPTH - fifo_count - inflight; in_ready SHALL be (credit > 0), derived only from registered state, with no combinational path from in_valid.
REQ-020 Issue latency: on a handshake in cycle t, add_a and add_b SHALL hold the pair and add_valid SHALL be high in cycle t+1 only.
- add_valid is low otherwise.
- add_a and add_b hold their last value when add_valid is low.
REQ-021 On add_res_valid with inflight > 0:
- add_res is written to the FIFO tail.
- It appears on out_data or out_valid in the next cycle at the earliest.
REQ-022 On add_res_valid with inflight == 0:
- The result SHALL be dropped.
- err_unexpected SHALL set and stay high until reset.
- Counters are unchanged.
REQ-023 Results SHALL leave in arrival order; out_data SHALL be stable while out_valid is high and out_ready is low.
REQ-024 Simultaneous events in one cycle SHALL all take effect:
- issue, result arrival and pop together;
- each counter updates by the net delta.
REQ-025 A push and pop at fifo_count == DEPTH SHALL both occur.
- This case only arises when the pop frees space in the same cycle, because credit prevents overflow.
REQ-026 fifo_count + inflight SHALL never exceed DEPTH; a push when full is impossible by construction and needs no handling.
REQ-027 FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 With rst_n low, outputs SHALL be:
- in_ready = 0, add_valid = 0, add_a = add_b = 0x0000;
- out_valid = 0, out_data = 0x0000;
- err_unexpected = 0;
- inflight, fifo_count and both FIFO pointers = 0.
REQ-029 Reset mid-operation SHALL discard everything in flight and buffered.
- Results arriving after reset release are treated as unexpected (REQ-022).
- The integrator resets the adder together with this block.
REQ-030 in_ready SHALL go high in the first cycle after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold:
- FP16_W = 16;
- fp16 constants ONE = 0x3C00, TWO = 0x4000, THREE = 0x4200, ZERO = 0x0000;
- the fp16_t typedef.
REQ-032 The result buffer SHALL be one sub-module, fp16_result_fifo.
- Synchronous, DEPTH entries.
- Ports: push, push_data, pop, head_data, empty, count.
- Credit and inflight logic stays in the top level.

Verification
REQ-033 Single add, adder model latency 12, out_ready = 1:
- drive in_a = 0x3C00, in_b = 0x4000;
- required: add_valid high exactly one cycle later with add_a = 0x3C00, add_b = 0x4000;
- required: out_valid with out_data = 0x4200 one cycle after add_res_valid.
REQ-034 Backpressure fill, DEPTH = 8, out_ready = 0, in_valid held high:
- required: exactly 8 issues, then in_ready = 0;
- required: after one pop, in_ready = 1 the next cycle and exactly one more issue.
REQ-035 Ordering: issue pairs giving sums 0x4200, 0x3C00, 0x4000 back-to-back -> required: out_data sequence is 0x4200, 0x3C00, 0x4000 with no loss.
REQ-036 Simultaneous issue, arrival and pop each cycle over 100 random cycles -> required: fifo_count + inflight never exceeds 8 and no result is dropped.
REQ-037 Pulse add_res_valid with nothing issued -> required: err_unexpected = 1 and stays high, out_valid stays 0.
REQ-038 Assert rst_n low with 3 adds in flight and 2 buffered:
- required while low: all outputs at REQ-028 values;
- required after release: the 3 late results raise err_unexpected and none reach out_data.
